ram_sync_param: RTL and testbench

//   Parametrised single-port synchronous RAM; generalises the fixed 8x256 data memory.

---
 rtl/ram_sync_param_if.sv | 24 ++
 rtl/ram_sync_param.sv | 127 ++++++++++++
 tb/tb_ram_sync_param.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_param_if.sv
// Request/response bundle between the CPU-side controller (master) and the RAM (slave).
interface ram_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] val;
    logic                  get;
    logic                  set;
    logic                  clear;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_valid;
    logic                  busy;

    modport master (
        output addr, val, get, set, clear,
        input  out, out_valid, busy
    );

    modport slave (
        input  addr, val, get, set, clear,
        output out, out_valid, busy
    );
endinterface

// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with clear sequencer; read data READ_LATENCY (1 or 2) cycles after get.
// No stalls: requests arriving while busy (clearing) are dropped, not held.
module ram_sync_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_sync_param_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST    = (ADDR_WIDTH+1)'(DEPTH - 1);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("ram_sync_param: READ_LATENCY must be 1 or 2");
        end
        if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("ram_sync_param: DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  fin_vld;
    logic [DATA_WIDTH-1:0] fin_dat;

    assign in_range = ({1'b0, bus.addr} < DEPTH_W);
    assign rd_dat   = in_range ? mem[bus.addr[IDX_W-1:0]] : '0;
    assign bus.busy = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_idx    = bus.addr[IDX_W-1:0];
        wr_dat    = bus.val;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (bus.set) begin
                    wr_en = in_range;
                end else if (bus.get) begin
                    rd_en = 1'b1;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = cnt[IDX_W-1:0];
                wr_dat  = '0;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Array has no reset so it can map onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_vld;
            logic [DATA_WIDTH-1:0] s1_dat;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld <= 1'b0;
                    s1_dat <= '0;
                end else begin
                    s1_vld <= rd_en;
                    if (rd_en) begin
                        s1_dat <= rd_dat;
                    end
                end
            end
            assign fin_vld = s1_vld;
            assign fin_dat = s1_dat;
        end else begin : g_lat1
            assign fin_vld = rd_en;
            assign fin_dat = rd_dat;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= fin_vld;
            if (fin_vld) begin
                bus.out <= fin_dat;
            end
        end
    end
endmodule

// File: tb/tb_ram_sync_param.sv
// Drives two RAM instances (DEPTH=200/LAT=1 and DEPTH=16/LAT=2) with shared stimulus
// and compares every cycle against an array/queue reference model.
module tb_ram_sync_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] val = '0;
    logic       get = 1'b0;
    logic       set = 1'b0;
    logic       clear = 1'b0;

    always #5 clk = ~clk;

    ram_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_a ();
    ram_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_b ();

    assign bus_a.addr = addr;  assign bus_b.addr = addr;
    assign bus_a.val = val;    assign bus_b.val = val;
    assign bus_a.get = get;    assign bus_b.get = get;
    assign bus_a.set = set;    assign bus_b.set = set;
    assign bus_a.clear = clear; assign bus_b.clear = clear;

    ram_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(1)) u_ram_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    ram_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .READ_LATENCY(2)) u_ram_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: clear zeroes the array at once and then just counts busy cycles,
    // since nothing is accepted while busy anyway.
    typedef struct packed {
        int         due;
        logic [7:0] d;
        logic       k;
    } rd_t;

    int         dep[2]  = '{200, 16};
    int         latv[2] = '{1, 2};
    logic [7:0] mmem[2][256];
    bit         mknown[2][256];
    int         busy_left[2];
    bit         exp_vld[2];
    logic [7:0] exp_out[2];
    bit         exp_k[2];
    rd_t        q0[$];
    rd_t        q1[$];
    int         cyc = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy_left[d] = 0;
            exp_vld[d]   = 0;
            exp_out[d]   = 8'h00;
            exp_k[d]     = 1;
            for (int i = 0; i < 256; i++) mknown[d][i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_edge();
        rd_t r;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            exp_vld[d] = 0;
            if (busy_left[d] > 0) begin
                busy_left[d]--;
            end else if (clear) begin
                for (int i = 0; i < dep[d]; i++) begin
                    mmem[d][i]   = 8'h00;
                    mknown[d][i] = 1;
                end
                busy_left[d] = dep[d];
            end else if (set) begin
                if (int'(addr) < dep[d]) begin
                    mmem[d][addr]   = val;
                    mknown[d][addr] = 1;
                end
            end else if (get) begin
                r.due = cyc + latv[d] - 1;
                if (int'(addr) < dep[d]) begin
                    r.d = mmem[d][addr];
                    r.k = mknown[d][addr];
                end else begin
                    r.d = 8'h00;
                    r.k = 1'b1;
                end
                if (d == 0) q0.push_back(r); else q1.push_back(r);
            end
            if (d == 0 && q0.size() > 0 && q0[0].due == cyc) r = q0.pop_front();
            else if (d == 1 && q1.size() > 0 && q1[0].due == cyc) r = q1.pop_front();
            else r.due = -1;
            if (r.due == cyc) begin
                exp_vld[d] = 1;
                exp_out[d] = r.d;
                exp_k[d]   = r.k;
            end
        end
    endtask

    task automatic check_all();
        check("a_busy", {31'd0, bus_a.busy}, {31'd0, busy_left[0] != 0});
        check("a_vld", {31'd0, bus_a.out_valid}, {31'd0, exp_vld[0]});
        if (exp_k[0]) check("a_out", {24'd0, bus_a.out}, {24'd0, exp_out[0]});
        check("b_busy", {31'd0, bus_b.busy}, {31'd0, busy_left[1] != 0});
        check("b_vld", {31'd0, bus_b.out_valid}, {31'd0, exp_vld[1]});
        if (exp_k[1]) check("b_out", {24'd0, bus_b.out}, {24'd0, exp_out[1]});
    endtask

    task automatic drive(input bit c, input bit s, input bit g, input logic [7:0] a,
                         input logic [7:0] v);
        clear = c; set = s; get = g; addr = a; val = v;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_idle();
        int n = 0;
        drive(0, 0, 0, 0, 0);
        while ((busy_left[0] != 0 || busy_left[1] != 0) && n < 400) begin
            step();
            n++;
        end
        check("clear_done", {30'd0, bus_a.busy, bus_b.busy}, 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // set 5=A5 then get 5
        drive(0, 1, 0, 8'd5, 8'hA5); step();
        drive(0, 0, 1, 8'd5, 8'h00); step();
        drive(0, 0, 0, 8'd0, 8'h00); step(); step();
        check("t1_out_a", {24'd0, bus_a.out}, 32'hA5);

        // back-to-back reads of 10,11,12
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'(i), 8'(10 + i)); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 8'(i), 8'h00); step();
        end
        drive(0, 0, 0, 0, 0); step(); step(); step();
        check("t2_out_b", {24'd0, bus_b.out}, 32'd12);

        // set and get together: set wins, no read
        drive(0, 1, 1, 8'd7, 8'd3); step();
        drive(0, 0, 0, 0, 0); step(); step();
        drive(0, 0, 1, 8'd7, 8'd0); step();
        drive(0, 0, 0, 0, 0); step(); step();
        check("t3_out_b", {24'd0, bus_b.out}, 32'd3);

        // fill, clear, ops dropped while busy, then read zeros
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 8'(i), 8'($urandom_range(1, 255))); step();
        end
        drive(1, 0, 0, 0, 0); step();
        for (int i = 0; i < 16; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 15)), 8'($urandom_range(1, 255)));
            step();
        end
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 8'(i), 0); step();
        end
        drive(0, 0, 0, 0, 0); step(); step(); step();

        // reset in the middle of a clear
        drive(0, 1, 0, 8'd3, 8'h5A); step();
        drive(0, 0, 1, 8'd3, 8'h00); step();
        drive(0, 0, 0, 0, 0); step(); step();
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // out-of-range write/read on the DEPTH=200 instance
        drive(0, 1, 0, 8'd199, 8'h77); step();
        drive(0, 1, 0, 8'd250, 8'd9); step();
        drive(0, 0, 1, 8'd250, 8'd0); step();
        check("t6_oob_vld", {31'd0, bus_a.out_valid}, 32'd1);
        check("t6_oob_out", {24'd0, bus_a.out}, 32'd0);
        drive(0, 0, 1, 8'd199, 8'd0); step();
        check("t6_keep", {24'd0, bus_a.out}, 32'h77);
        drive(0, 0, 0, 0, 0); step(); step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 19));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 5), a, 8'($urandom));
            step();
        end
        wait_idle();
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
